id_stage: RTL

Instruction decode stage of the RV32I 5-stage pipeline, sitting directly downstream of instruction fetch and upstream of execute. Each cycle it takes the fetched instruction word and PC, decodes the opcode class, and builds the sign-extended immediate. It reads two operands from the 32x32 integer register file, which it owns and which is written by the write-back stage. It detects load-use hazards and registers everything into the ID/EX pipeline register, inserting bubbles on flush or hazard.

---
 rtl/id_stage.sv | 215 +++++++++++++++++++++
 1 files changed

// File: rtl/id_stage.sv
// RV32I decode stage: opcode/immediate decode, 32x32 register file with
// write-through bypass, load-use hazard detection and the ID/EX pipeline register.
`timescale 1ns/1ps
module id_stage (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] inst_id,
  input  logic [31:2] pc_id,
  input  logic        stall,
  input  logic        rst_pipe,
  input  logic [4:0]  wbk_rd_reg,
  input  logic [31:0] wbk_data,
  input  logic        wbk_wen,
  output logic        ld_hazard,
  output logic [31:2] pc_ex,
  output logic [31:0] rs1_data_ex,
  output logic [31:0] rs2_data_ex,
  output logic [31:0] imm_ex,
  output logic [4:0]  rd_ex,
  output logic        rd_wen_ex,
  output logic [2:0]  funct3_ex,
  output logic        funct7b5_ex,
  output logic        cmd_lui_ex,
  output logic        cmd_auipc_ex,
  output logic        cmd_jal_ex,
  output logic        cmd_jalr_ex,
  output logic        cmd_br_ex,
  output logic        cmd_ld_ex,
  output logic        cmd_st_ex,
  output logic        cmd_alui_ex,
  output logic        cmd_alu_ex,
  output logic        cmd_ecall_ex,
  output logic        ill_inst_ex
);

  localparam logic [4:0] OPC_LUI    = 5'b01101;
  localparam logic [4:0] OPC_AUIPC  = 5'b00101;
  localparam logic [4:0] OPC_JAL    = 5'b11011;
  localparam logic [4:0] OPC_JALR   = 5'b11001;
  localparam logic [4:0] OPC_BRANCH = 5'b11000;
  localparam logic [4:0] OPC_LOAD   = 5'b00000;
  localparam logic [4:0] OPC_STORE  = 5'b01000;
  localparam logic [4:0] OPC_OPIMM  = 5'b00100;
  localparam logic [4:0] OPC_OP     = 5'b01100;
  localparam logic [4:0] OPC_SYSTEM = 5'b11100;

  logic [4:0]  opcode;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [4:0]  rd;
  logic        quad_ok;

  logic        dec_lui;
  logic        dec_auipc;
  logic        dec_jal;
  logic        dec_jalr;
  logic        dec_br;
  logic        dec_ld;
  logic        dec_st;
  logic        dec_alui;
  logic        dec_alu;
  logic        dec_ecall;
  logic        dec_ill;
  logic        dec_rd_wen;
  logic        use_rs1;
  logic        use_rs2;
  logic [31:0] dec_imm;

  logic [31:0] regs [32];
  logic [31:0] rs1_data;
  logic [31:0] rs2_data;

  assign opcode  = inst_id[6:2];
  assign rs1     = inst_id[19:15];
  assign rs2     = inst_id[24:20];
  assign rd      = inst_id[11:7];
  assign quad_ok = (inst_id[1:0] == 2'b11);

  // Opcode class decode; a non-32-bit encoding or unknown opcode leaves every class flag low.
  always_comb begin
    dec_lui   = 1'b0;
    dec_auipc = 1'b0;
    dec_jal   = 1'b0;
    dec_jalr  = 1'b0;
    dec_br    = 1'b0;
    dec_ld    = 1'b0;
    dec_st    = 1'b0;
    dec_alui  = 1'b0;
    dec_alu   = 1'b0;
    dec_ecall = 1'b0;
    if (quad_ok) begin
      case (opcode)
        OPC_LUI:    dec_lui   = 1'b1;
        OPC_AUIPC:  dec_auipc = 1'b1;
        OPC_JAL:    dec_jal   = 1'b1;
        OPC_JALR:   dec_jalr  = 1'b1;
        OPC_BRANCH: dec_br    = 1'b1;
        OPC_LOAD:   dec_ld    = 1'b1;
        OPC_STORE:  dec_st    = 1'b1;
        OPC_OPIMM:  dec_alui  = 1'b1;
        OPC_OP:     dec_alu   = 1'b1;
        OPC_SYSTEM: dec_ecall = (inst_id[31:7] == 25'd0);
        default:    ;
      endcase
    end
  end

  assign dec_ill = ~(dec_lui | dec_auipc | dec_jal | dec_jalr | dec_br |
                     dec_ld | dec_st | dec_alui | dec_alu | dec_ecall);

  assign dec_rd_wen = (dec_lui | dec_auipc | dec_jal | dec_jalr | dec_ld |
                       dec_alui | dec_alu) & (rd != 5'd0);

  assign use_rs1 = dec_jalr | dec_br | dec_ld | dec_st | dec_alui | dec_alu;
  assign use_rs2 = dec_br | dec_st | dec_alu;

  always_comb begin
    dec_imm = 32'd0;
    if (dec_jalr | dec_ld | dec_alui)
      dec_imm = {{20{inst_id[31]}}, inst_id[31:20]};
    else if (dec_st)
      dec_imm = {{20{inst_id[31]}}, inst_id[31:25], inst_id[11:7]};
    else if (dec_br)
      dec_imm = {{20{inst_id[31]}}, inst_id[7], inst_id[30:25], inst_id[11:8], 1'b0};
    else if (dec_lui | dec_auipc)
      dec_imm = {inst_id[31:12], 12'd0};
    else if (dec_jal)
      dec_imm = {{12{inst_id[31]}}, inst_id[19:12], inst_id[20], inst_id[30:21], 1'b0};
  end

  // Register file: x0 is never written so it stays at its reset value of zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) regs[i] <= 32'd0;
    end else if (wbk_wen && (wbk_rd_reg != 5'd0)) begin
      regs[wbk_rd_reg] <= wbk_data;
    end
  end

  always_comb begin
    rs1_data = regs[rs1];
    rs2_data = regs[rs2];
    if (wbk_wen && (wbk_rd_reg != 5'd0) && (wbk_rd_reg == rs1)) rs1_data = wbk_data;
    if (wbk_wen && (wbk_rd_reg != 5'd0) && (wbk_rd_reg == rs2)) rs2_data = wbk_data;
  end

  // rd_wen_ex already implies rd_ex != 0, so x0 sources never raise a hazard.
  assign ld_hazard = cmd_ld_ex & rd_wen_ex &
                     ((use_rs1 & (rs1 == rd_ex)) | (use_rs2 & (rs2 == rd_ex)));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_ex        <= '0;
      rs1_data_ex  <= '0;
      rs2_data_ex  <= '0;
      imm_ex       <= '0;
      rd_ex        <= '0;
      rd_wen_ex    <= 1'b0;
      funct3_ex    <= '0;
      funct7b5_ex  <= 1'b0;
      cmd_lui_ex   <= 1'b0;
      cmd_auipc_ex <= 1'b0;
      cmd_jal_ex   <= 1'b0;
      cmd_jalr_ex  <= 1'b0;
      cmd_br_ex    <= 1'b0;
      cmd_ld_ex    <= 1'b0;
      cmd_st_ex    <= 1'b0;
      cmd_alui_ex  <= 1'b0;
      cmd_alu_ex   <= 1'b0;
      cmd_ecall_ex <= 1'b0;
      ill_inst_ex  <= 1'b0;
    end else if (rst_pipe || (!stall && ld_hazard)) begin
      pc_ex        <= '0;
      rs1_data_ex  <= '0;
      rs2_data_ex  <= '0;
      imm_ex       <= '0;
      rd_ex        <= '0;
      rd_wen_ex    <= 1'b0;
      funct3_ex    <= '0;
      funct7b5_ex  <= 1'b0;
      cmd_lui_ex   <= 1'b0;
      cmd_auipc_ex <= 1'b0;
      cmd_jal_ex   <= 1'b0;
      cmd_jalr_ex  <= 1'b0;
      cmd_br_ex    <= 1'b0;
      cmd_ld_ex    <= 1'b0;
      cmd_st_ex    <= 1'b0;
      cmd_alui_ex  <= 1'b0;
      cmd_alu_ex   <= 1'b0;
      cmd_ecall_ex <= 1'b0;
      ill_inst_ex  <= 1'b0;
    end else if (!stall) begin
      pc_ex        <= pc_id;
      rs1_data_ex  <= rs1_data;
      rs2_data_ex  <= rs2_data;
      imm_ex       <= dec_imm;
      rd_ex        <= rd;
      rd_wen_ex    <= dec_rd_wen;
      funct3_ex    <= inst_id[14:12];
      funct7b5_ex  <= inst_id[30];
      cmd_lui_ex   <= dec_lui;
      cmd_auipc_ex <= dec_auipc;
      cmd_jal_ex   <= dec_jal;
      cmd_jalr_ex  <= dec_jalr;
      cmd_br_ex    <= dec_br;
      cmd_ld_ex    <= dec_ld;
      cmd_st_ex    <= dec_st;
      cmd_alui_ex  <= dec_alui;
      cmd_alu_ex   <= dec_alu;
      cmd_ecall_ex <= dec_ecall;
      ill_inst_ex  <= dec_ill;
    end
  end

endmodule
